// File: rtl/fixed_point_divider_seq.sv
// fixed_point_divider_seq
//   Iterative restoring radix-2 fixed-point divider, out = a / b, one quotient
//   bit per cycle. Selectable signed/unsigned, truncate or round-half-to-even,
//   saturating on overflow, valid/ready handshake on both sides.
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   inValid/inReady     : operand handshake (accepted only in IDLE)
//   a [A1+A2], b [B1+B2]: dividend / divisor
//   outValid/outReady   : result handshake; out/divByZero/overflow held until taken
//   out [O1+O2]         : quotient
//   divByZero, overflow : b was zero / result saturated
// Constraint: O2 + B2 >= A2.
module fixed_point_divider_seq #(
  parameter int A1         = 4,
  parameter int A2         = 4,
  parameter int B1         = 4,
  parameter int B2         = 4,
  parameter int O1         = 4,
  parameter int O2         = 4,
  parameter bit SIGNED     = 1'b1,
  parameter bit ROUND_MODE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [A1+A2-1:0] a,
  input  logic [B1+B2-1:0] b,
  output logic             outValid,
  input  logic             outReady,
  output logic [O1+O2-1:0] out,
  output logic             divByZero,
  output logic             overflow
);
  localparam int AW = A1 + A2;
  localparam int BW = B1 + B2;
  localparam int OW = O1 + O2;
  localparam int S  = O2 + B2 - A2;
  localparam int N  = AW + S;
  localparam int QW = N + 1;                       // quotient incl. guard bit
  localparam int MW = (QW > OW + 1) ? QW : OW + 1; // wide enough for range check
  localparam int CW = $clog2(QW + 1);

  localparam logic [OW-1:0] MAX_POS = SIGNED ? {1'b0, {(OW-1){1'b1}}} : {OW{1'b1}};
  localparam logic [OW-1:0] MIN_NEG = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] num_q, num_d;   // numerator, shifted out MSB first
  logic [BW-1:0] den_q, den_d;
  logic [BW-1:0] rem_q, rem_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic [OW-1:0] out_q, out_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic          a_neg, b_neg;
  logic [AW-1:0] a_mag;
  logic [BW-1:0] b_mag;
  logic [BW:0]   rem_sh, diff;
  logic          ge;
  logic [MW-1:0] m_base, m_rnd, lim;

  assign a_neg = SIGNED && a[AW-1];
  assign b_neg = SIGNED && b[BW-1];
  assign a_mag = a_neg ? AW'(0) - a : a;
  assign b_mag = b_neg ? BW'(0) - b : b;

  // Partial remainder is always < den, so a borrow out of the (BW+1)-bit
  // subtraction is exactly the "does not fit" condition.
  assign rem_sh = {rem_q, num_q[QW-1]};
  assign diff   = rem_sh - {1'b0, den_q};
  assign ge     = !diff[BW];

  // quo_q[0] is the guard bit, remainder != 0 is sticky.
  assign m_base = MW'(quo_q[QW-1:1]);
  assign m_rnd  = m_base + MW'(ROUND_MODE && quo_q[0] && ((|rem_q) || m_base[0]));
  // Negative results may reach one step further than positive ones.
  assign lim    = SIGNED ? (MW'(1) << (OW - 1)) - MW'(!neg_q)
                         : (MW'(1) << OW) - MW'(1);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    out_d   = out_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (inValid) begin
          neg_d = a_neg ^ b_neg;
          den_d = b_mag;
          num_d = QW'(a_mag) << (S + 1);
          rem_d = '0;
          quo_d = '0;
          cnt_d = '0;
          dbz_d = (b == '0);
          ovf_d = 1'b0;
          if (b == '0) begin
            out_d   = a_neg ? MIN_NEG : MAX_POS;
            state_d = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = ge ? diff[BW-1:0] : rem_sh[BW-1:0];
        quo_d = {quo_q[QW-2:0], ge};
        num_d = num_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(QW - 1)) state_d = ROUND;
      end
      ROUND: begin
        if (m_rnd > lim) begin
          ovf_d = 1'b1;
          out_d = neg_q ? MIN_NEG : MAX_POS;
        end else begin
          out_d = neg_q ? OW'(0) - m_rnd[OW-1:0] : m_rnd[OW-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        if (outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign inReady   = (state_q == IDLE) && !reset;
  assign outValid  = (state_q == DONE);
  assign out       = out_q;
  assign divByZero = dbz_q;
  assign overflow  = ovf_q;
endmodule

// File: doc/fixed_point_divider_seq.md
# fixed_point_divider_seq

Iterative, handshaked fixed-point divider computing out = a / b with independently parameterised operand and result formats. It is selectable signed or unsigned, rounds by truncation or round-half-to-even, and saturates on overflow. It is the area-lean, flow-controlled successor to the fully pipelined fixed-point divider. It is intended for datapaths that issue divides sparsely and need backpressure: normalisation units and reciprocal seeding.

## Interface
- A1, 4, integer bits of a (sign included when SIGNED=1)
- A2, 4, fraction bits of a
- B1, 4, integer bits of b
- B2, 4, fraction bits of b
- O1, 4, integer bits of out
- O2, 4, fraction bits of out; requires O2 + B2 >= A2
- SIGNED, 1, 1 = two's-complement operands and result, 0 = unsigned
- ROUND_MODE, 1, 0 = truncate toward zero, 1 = round half to even
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- inValid  in  1  operands present
- inReady  out  1  block can accept operands
- a  in  A1+A2  dividend
- b  in  B1+B2  divisor
- outValid  out  1  result present
- outReady  in  1  consumer takes result
- out  out  O1+O2  quotient
- divByZero  out  1  b was zero for this result
- overflow  out  1  result saturated

## Operation
- Derived widths: S = O2 + B2 - A2 and N = A1 + A2 + S.
- Numerator: |a| << (S+1). The extra bit is the guard bit.
- Denominator: |b|.
- When SIGNED=1, magnitudes are formed on load. Result sign = sign(a) XOR sign(b).
- States: IDLE, DIV, ROUND, DONE.
- IDLE: inReady=1. On inValid && inReady, latch the operand magnitudes, the result sign and the zero-divisor test.
  - If b == 0, go to DONE with divByZero=1, overflow=0.
  - out = the most positive representable value, or the most negative if SIGNED and a < 0.
  - If b == 0 and a == 0, out = the most positive value.
  - Otherwise clear the partial remainder and iteration counter, then go to DIV.
- DIV: restoring radix-2, one quotient bit per cycle, MSB first, for N+1 cycles. Then go to ROUND.
- ROUND: quotient magnitude q is N+1 bits. Guard g = q[0]. Sticky s = (final remainder != 0). Base m = q >> 1.
  - ROUND_MODE=1: increment m when g && (s || m[0]).
  - ROUND_MODE=0: m unchanged.
  - Negate m if the result is negative.
- Range check: the result must fit O1+O2 bits.
  - SIGNED, positive: magnitude <= 2^(O1+O2-1) - 1.
  - SIGNED, negative: magnitude <= 2^(O1+O2-1).
  - Unsigned: magnitude <= 2^(O1+O2) - 1.
  - Otherwise saturate to the same-signed extreme and set overflow=1. Then go to DONE.
- DONE: outValid=1. out, divByZero and overflow stay stable until outReady. On outValid && outReady, go to IDLE.
- A new operand is accepted only in IDLE. Operations do not overlap.
- inReady = (state == IDLE) && !reset.

## Timing
- Reset values: outValid=0, out=0, divByZero=0, overflow=0, state=IDLE.
- inReady is 0 during reset cycles and 1 in the first cycle after reset deasserts.
- Reset in any state (DIV, ROUND, DONE) aborts the operation. The pending result is discarded and never presented.
- Latency, accept edge to first cycle with outValid=1:
  - Normal divide: N+3 cycles (1 load, N+1 DIV, 1 ROUND). With the default parameters N=12, giving 15 cycles.
  - b == 0: 1 cycle.
- Result handshake: the result transfers on the edge where outValid && outReady.
  - inReady rises the cycle after the transfer.
  - There is no same-cycle accept of a new operand while the result is transferring. Minimum issue interval = latency + 1.
- inValid asserted while inReady=0 is ignored. Operands do not need to be held except in the accept cycle.
- Outputs are registered. There are no combinational paths from inputs to out, outValid, divByZero or overflow.

## Test plan
All scenarios use default parameters unless stated otherwise.
- Exact divide: a=0x18 (1.5), b=0x08 (0.5) -> out=0x30 (3.0), both flags 0, outValid exactly 15 cycles after the accept edge.
- Rounding tie: a=0x03, b=0x20 (2.0) -> ROUND_MODE=1 gives out=0x02, ROUND_MODE=0 gives out=0x01.
- Signed inexact: a=0xF0 (-1.0), b=0x30 (3.0) -> out=0xFB in both modes.
- Saturation:
  - a=0x70 (7.0), b=0x01 -> out=0x7F, overflow=1.
  - a=0x80 (-8.0), b=0x10 (1.0) -> out=0x80, overflow=0.
- Divide by zero: a=0x90, b=0x00 -> out=0x80, divByZero=1, outValid 1 cycle after accept.
  - Repeat with SIGNED=0, a=0x90 -> out=0xFF.
- Flow control and reset:
  - Hold outReady=0 for 10 cycles: out stays stable and inReady stays 0.
  - Back-to-back requests with inValid held high: every result is correct in order, issue interval 16 cycles.
  - Assert reset mid-DIV: outValid never rises for the aborted op, and the next op completes correctly.
